// File: rtl/fwd_hazard_if.sv
// Decode-side request and forwarding-result bundle for fwd_hazard_unit.
// The perf counter signals exist only when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_if #(
   parameter int XLEN         = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int FWD_DEPTH    = 2
);
   logic                         stall_ext_i;
   logic                         flush_i;
   logic                         id_valid_i;
   logic [NUM_RD_PORTS*5-1:0]    id_rs_i;
   logic [NUM_RD_PORTS*XLEN-1:0] id_rf_data_i;
   logic [4:0]                   id_rd_i;
   logic                         id_we_i;
   logic                         id_is_load_i;
   logic [FWD_DEPTH*XLEN-1:0]    stage_data_i;
   logic [NUM_RD_PORTS*XLEN-1:0] fwd_data_o;
   logic [NUM_RD_PORTS-1:0]      fwd_hit_o;
   logic                         hazard_stall_o;
`ifdef FWD_HAZARD_PERF_EN
   logic [31:0]                  perf_stall_cnt_o;
   logic [31:0]                  perf_fwd_cnt_o;
`endif

   modport master (
      output stall_ext_i, flush_i, id_valid_i, id_rs_i, id_rf_data_i,
      output id_rd_i, id_we_i, id_is_load_i, stage_data_i,
`ifdef FWD_HAZARD_PERF_EN
      input  perf_stall_cnt_o, perf_fwd_cnt_o,
`endif
      input  fwd_data_o, fwd_hit_o, hazard_stall_o
   );

   modport slave (
      input  stall_ext_i, flush_i, id_valid_i, id_rs_i, id_rf_data_i,
      input  id_rd_i, id_we_i, id_is_load_i, stage_data_i,
`ifdef FWD_HAZARD_PERF_EN
      output perf_stall_cnt_o, perf_fwd_cnt_o,
`endif
      output fwd_data_o, fwd_hit_o, hazard_stall_o
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding and load-use hazard detection with a private in-flight scoreboard.
// Define FWD_HAZARD_PERF_EN to add saturating stall / forward event counters.
module fwd_hazard_unit #(
   parameter int XLEN         = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int FWD_DEPTH    = 2,
   parameter int LOAD_LAT     = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   fwd_hazard_if.slave  bus
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       load;
   } sb_entry_t;

   sb_entry_t                    r_sb [FWD_DEPTH];
   logic [NUM_RD_PORTS*XLEN-1:0] w_fwd_data;
   logic [NUM_RD_PORTS-1:0]      w_fwd_hit;
   logic [NUM_RD_PORTS-1:0]      w_stall_req;
   logic                         w_hazard_stall;

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      logic [4:0]      w_rs;
      logic [XLEN-1:0] w_rf;
      logic            w_match;
      logic            w_ready;
      logic [XLEN-1:0] w_win_data;

      assign w_rs = bus.id_rs_i[p*5 +: 5];
      assign w_rf = bus.id_rf_data_i[p*XLEN +: XLEN];

      // Oldest-to-youngest scan so the youngest match overwrites and wins.
      // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
      always_comb begin
         w_match    = 1'b0;
         w_ready    = 1'b0;
         w_win_data = '0;
         for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_sb[k].valid && r_sb[k].we && (r_sb[k].rd != 5'd0) && (r_sb[k].rd == w_rs)) begin
               w_match    = 1'b1;
               w_ready    = !(r_sb[k].load && (k < LOAD_LAT));
               w_win_data = bus.stage_data_i[k*XLEN +: XLEN];
            end
         end
      end

      assign w_fwd_hit[p]   = (w_rs != 5'd0) && w_match && w_ready;
      assign w_stall_req[p] = (w_rs != 5'd0) && w_match && !w_ready;
      assign w_fwd_data[p*XLEN +: XLEN] = (w_rs == 5'd0) ? '0 :
                                          w_fwd_hit[p]   ? w_win_data : w_rf;
   end

   assign w_hazard_stall     = bus.id_valid_i && !bus.flush_i && (|w_stall_req);
   assign bus.fwd_data_o     = w_fwd_data;
   assign bus.fwd_hit_o      = w_fwd_hit;
   assign bus.hazard_stall_o = w_hazard_stall;

   // NOTE: sequential state uses non-blocking assignments so every entry shifts from its pre-edge value.
   // NOTE: the scoreboard is a handful of flops, not a RAM, so every entry is reset explicitly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < FWD_DEPTH; k++) begin
            r_sb[k] <= '0;
         end
      end else if (!bus.stall_ext_i) begin
         for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
            r_sb[k] <= r_sb[k-1];
         end
         if (bus.flush_i || w_hazard_stall || !bus.id_valid_i) begin
            r_sb[0] <= '0;
         end else begin
            r_sb[0] <= '{valid: 1'b1, rd: bus.id_rd_i, we: bus.id_we_i, load: bus.id_is_load_i};
         end
      end
   end

`ifdef FWD_HAZARD_PERF_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_fwd_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_stall_cnt <= '0;
         r_perf_fwd_cnt   <= '0;
      end else if (!bus.stall_ext_i) begin
         if (w_hazard_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
         if ((|w_fwd_hit) && (r_perf_fwd_cnt != 32'hFFFF_FFFF)) begin
            r_perf_fwd_cnt <= r_perf_fwd_cnt + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cnt_o = r_perf_stall_cnt;
   assign bus.perf_fwd_cnt_o   = r_perf_fwd_cnt;
`endif

endmodule
